// File: rtl/wash_pkg.sv
// Shared types and default constants for the wash-machine sense/timer stage.
package wash_pkg;

    // Phase-timer state; the encoding is fixed so a state decode is stable across builds.
    typedef enum logic [1:0] {
        TMR_IDLE    = 2'b00,
        TMR_RUN     = 2'b01,
        TMR_EXPIRED = 2'b10
    } tmr_state_t;

    localparam int DEF_CLK_DIV     = 100;
    localparam int DEF_CYCLE_TICKS = 30;
    localparam int DEF_SPIN_TICKS  = 10;
    localparam int DEF_DEB_LEN     = 4;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/level_debounce.sv
// Level-sensor conditioner: 2-flop synchronizer followed by a stability counter.
// The output only follows the synchronized value after DEB_LEN consecutive
// clocks of disagreement, so raw-edge-to-output latency is 2+DEB_LEN clocks.
module level_debounce
    import wash_pkg::*;
#(
    parameter int DEB_LEN = DEF_DEB_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DEB_LEN < 2) ? 1 : $clog2(DEB_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    // Bring the asynchronous sensor into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count clocks of disagreement; accept the new level on the DEB_LEN-th one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/wash_sense_timer.sv
// Stimulus stage for the washing-machine controller: debounced fill/drain
// levels, a sticky sensor-fault flag, and the wash-cycle and spin timers that
// share one prescaler. Timeouts are decodes of the registered timer state.
module wash_sense_timer
    import wash_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
    parameter int SPIN_TICKS  = DEF_SPIN_TICKS,
    parameter int DEB_LEN     = DEF_DEB_LEN,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic level_hi_raw,
    input  logic level_lo_raw,
    input  logic motor_on,
    input  logic drain_value_on,
    output logic filled,
    output logic drained,
    output logic cycle_timeout,
    output logic spin_timeout,
    output logic sensor_fault,
    output logic timer_busy
);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYCLE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_TICKS - 1);

    logic             w_filled;
    logic             w_drained;
    logic             w_cyc_en;
    logic             w_spin_en;
    logic             w_tick;
    logic             w_start;
    logic             w_any_run;
    logic [CNT_W-1:0] w_pre_nxt;

    tmr_state_t       r_cyc_state;
    tmr_state_t       w_cyc_state_nxt;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] w_cyc_cnt_nxt;

    tmr_state_t       r_spin_state;
    tmr_state_t       w_spin_state_nxt;
    logic [CNT_W-1:0] r_spin_cnt;
    logic [CNT_W-1:0] w_spin_cnt_nxt;

    logic [CNT_W-1:0] r_pre;
    logic             r_fault;

    level_debounce #(.DEB_LEN(DEB_LEN)) u_deb_hi (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (level_hi_raw),
        .o_level (w_filled)
    );

    level_debounce #(.DEB_LEN(DEB_LEN)) u_deb_lo (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (level_lo_raw),
        .o_level (w_drained)
    );

    // Cycle wins if both are requested, so spin is held off while the motor runs.
    assign w_cyc_en  = motor_on;
    assign w_spin_en = drain_value_on & w_drained & ~motor_on;
    assign w_tick    = (r_pre == PRE_LAST);
    assign w_any_run = (r_cyc_state == TMR_RUN) || (r_spin_state == TMR_RUN);
    assign w_start   = ((r_cyc_state == TMR_IDLE) && w_cyc_en) ||
                       ((r_spin_state == TMR_IDLE) && w_spin_en);

    // Wash-cycle timer next state: abort on enable loss, expire on the last tick.
    always_comb begin
        w_cyc_state_nxt = r_cyc_state;
        w_cyc_cnt_nxt   = r_cyc_cnt;
        case (r_cyc_state)
            TMR_IDLE: begin
                if (w_cyc_en) begin
                    w_cyc_state_nxt = TMR_RUN;
                    w_cyc_cnt_nxt   = '0;
                end
            end
            TMR_RUN: begin
                if (!w_cyc_en) begin
                    w_cyc_state_nxt = TMR_IDLE;
                    w_cyc_cnt_nxt   = '0;
                end else if (w_tick) begin
                    if (r_cyc_cnt == CYC_LAST) begin
                        w_cyc_state_nxt = TMR_EXPIRED;
                        w_cyc_cnt_nxt   = '0;
                    end else begin
                        w_cyc_cnt_nxt = r_cyc_cnt + CNT_W'(1);
                    end
                end
            end
            TMR_EXPIRED: begin
                if (!w_cyc_en) w_cyc_state_nxt = TMR_IDLE;
            end
            default: begin
                w_cyc_state_nxt = TMR_IDLE;
                w_cyc_cnt_nxt   = '0;
            end
        endcase
    end

    // Spin timer next state: same shape as the cycle timer with its own length.
    always_comb begin
        w_spin_state_nxt = r_spin_state;
        w_spin_cnt_nxt   = r_spin_cnt;
        case (r_spin_state)
            TMR_IDLE: begin
                if (w_spin_en) begin
                    w_spin_state_nxt = TMR_RUN;
                    w_spin_cnt_nxt   = '0;
                end
            end
            TMR_RUN: begin
                if (!w_spin_en) begin
                    w_spin_state_nxt = TMR_IDLE;
                    w_spin_cnt_nxt   = '0;
                end else if (w_tick) begin
                    if (r_spin_cnt == SPIN_LAST) begin
                        w_spin_state_nxt = TMR_EXPIRED;
                        w_spin_cnt_nxt   = '0;
                    end else begin
                        w_spin_cnt_nxt = r_spin_cnt + CNT_W'(1);
                    end
                end
            end
            TMR_EXPIRED: begin
                if (!w_spin_en) w_spin_state_nxt = TMR_IDLE;
            end
            default: begin
                w_spin_state_nxt = TMR_IDLE;
                w_spin_cnt_nxt   = '0;
            end
        endcase
    end

    // Prescaler restarts on any timer start and only free-runs while a timer is in RUN.
    always_comb begin
        w_pre_nxt = '0;
        if (!w_start && w_any_run && !w_tick) w_pre_nxt = r_pre + CNT_W'(1);
    end

    // State registers for both timers and the shared prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc_state  <= TMR_IDLE;
            r_cyc_cnt    <= '0;
            r_spin_state <= TMR_IDLE;
            r_spin_cnt   <= '0;
            r_pre        <= '0;
        end else begin
            r_cyc_state  <= w_cyc_state_nxt;
            r_cyc_cnt    <= w_cyc_cnt_nxt;
            r_spin_state <= w_spin_state_nxt;
            r_spin_cnt   <= w_spin_cnt_nxt;
            r_pre        <= w_pre_nxt;
        end
    end

    // Remember any moment where full and empty were both reported.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_fault <= 1'b0;
        else        r_fault <= r_fault | (w_filled & w_drained);
    end

    assign filled        = w_filled;
    assign drained       = w_drained;
    assign cycle_timeout = (r_cyc_state == TMR_EXPIRED);
    assign spin_timeout  = (r_spin_state == TMR_EXPIRED);
    assign sensor_fault  = r_fault | (w_filled & w_drained);
    assign timer_busy    = (r_cyc_state == TMR_RUN) || (r_spin_state == TMR_RUN);

endmodule
